// File: rtl/decode_stage_if.sv
// Fetch->decode->execute handshake bundle for decode_stage.
// slave: the decode stage; master: the surrounding fetch/execute logic.
interface decode_stage_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_pc;
  logic [31:0]         in_instr;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [13:0]         out_ctrl;
  logic [XLEN-1:0]     out_imm;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic [2:0]          out_func3;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_ctrl, out_imm, out_alu_op, out_func3
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_ctrl, out_imm, out_alu_op, out_func3
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32 decode stage with a 2-entry skid buffer and flush.
// Optional M-extension decode enabled by defining DECODE_MEXT_EN.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RV32E    = 0,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_stage: only XLEN=32 is supported");
  end
  if (ALU_OP_W < 4) begin : g_aluw_chk
    $error("decode_stage: ALU_OP_W must be at least 4");
  end

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  localparam int unsigned C_WEN    = 0;
  localparam int unsigned C_RS1    = 1;
  localparam int unsigned C_RS2    = 2;
  localparam int unsigned C_IMM    = 3;
  localparam int unsigned C_BR     = 4;
  localparam int unsigned C_JAL    = 5;
  localparam int unsigned C_JALR   = 6;
  localparam int unsigned C_OP1Z   = 7;
  localparam int unsigned C_OP1PC  = 8;
  localparam int unsigned C_OP2F   = 9;
  localparam int unsigned C_ILL    = 10;
  localparam int unsigned C_MRD    = 11;
  localparam int unsigned C_MWR    = 12;
  localparam int unsigned C_MULDIV = 13;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [13:0]         ctrl;
    logic [XLEN-1:0]     imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          func3;
  } bundle_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [13:0] ctrl;
  logic [31:0] imm_sel;
  logic [3:0]  alu4;
  logic        ill;
  bundle_t     dec;

  always_comb begin
    ctrl    = '0;
    imm_sel = '0;
    alu4    = '0;
    ill     = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl[C_WEN] = 1'b1;
        ctrl[C_RS1] = 1'b1;
        ctrl[C_RS2] = 1'b1;
        alu4        = {f7[5], f3};
        if (f7 == 7'b0000000) begin
          ill = 1'b0;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          ill = 1'b0;
`ifdef DECODE_MEXT_EN
        end else if (f7 == 7'b0000001) begin
          ctrl[C_MULDIV] = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        ctrl[C_WEN] = 1'b1;
        ctrl[C_RS1] = 1'b1;
        ctrl[C_IMM] = 1'b1;
        imm_sel     = imm_i;
        alu4        = {1'b0, f3};
        if (f3 == 3'b001) begin
          ill = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          alu4[3] = f7[5];
          ill     = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end
      end
      OPC_LOAD: begin
        ctrl[C_WEN] = 1'b1;
        ctrl[C_RS1] = 1'b1;
        ctrl[C_IMM] = 1'b1;
        ctrl[C_MRD] = 1'b1;
        imm_sel     = imm_i;
        ill         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        ctrl[C_RS1] = 1'b1;
        ctrl[C_RS2] = 1'b1;
        ctrl[C_IMM] = 1'b1;
        ctrl[C_MWR] = 1'b1;
        imm_sel     = imm_s;
        ill         = f3[2] || (f3 == 3'b011);
      end
      OPC_BRANCH: begin
        ctrl[C_RS1] = 1'b1;
        ctrl[C_RS2] = 1'b1;
        ctrl[C_BR]  = 1'b1;
        imm_sel     = imm_b;
        ill         = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI: begin
        ctrl[C_WEN]  = 1'b1;
        ctrl[C_IMM]  = 1'b1;
        ctrl[C_OP1Z] = 1'b1;
        imm_sel      = imm_u;
      end
      OPC_AUIPC: begin
        ctrl[C_WEN]   = 1'b1;
        ctrl[C_IMM]   = 1'b1;
        ctrl[C_OP1PC] = 1'b1;
        imm_sel       = imm_u;
      end
      OPC_JAL: begin
        ctrl[C_WEN]   = 1'b1;
        ctrl[C_JAL]   = 1'b1;
        ctrl[C_OP1PC] = 1'b1;
        ctrl[C_OP2F]  = 1'b1;
        imm_sel       = imm_j;
      end
      OPC_JALR: begin
        ctrl[C_WEN]   = 1'b1;
        ctrl[C_RS1]   = 1'b1;
        ctrl[C_JALR]  = 1'b1;
        ctrl[C_OP1PC] = 1'b1;
        ctrl[C_OP2F]  = 1'b1;
        imm_sel       = imm_i;
        ill           = (f3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase

    // RV32E: only register fields the instruction actually uses are range-checked
    if (RV32E != 0) begin
      if ((ctrl[C_WEN] && instr[11]) || (ctrl[C_RS1] && instr[19]) ||
          (ctrl[C_RS2] && instr[24])) begin
        ill = 1'b1;
      end
    end

    // Illegal entries still flow downstream but must not cause side effects
    if (ill) begin
      ctrl[C_WEN]  = 1'b0;
      ctrl[C_MRD]  = 1'b0;
      ctrl[C_MWR]  = 1'b0;
      ctrl[C_BR]   = 1'b0;
      ctrl[C_JAL]  = 1'b0;
      ctrl[C_JALR] = 1'b0;
    end
    ctrl[C_ILL] = ill;

    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.ctrl   = ctrl;
    dec.imm    = imm_sel;
    dec.alu_op = ALU_OP_W'(alu4);
    dec.func3  = f3;
  end

  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    accept, main_free;

  assign accept    = bus.in_valid && !skid_valid_q;
  assign main_free = !main_valid_q || bus.out_ready;

  // The skid can only be occupied while in_ready is low, so a draining
  // main register refills from the skid and never sees a same-cycle accept.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_d = dec;
        end
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready   = !skid_valid_q;
  assign bus.out_valid  = main_valid_q;
  assign bus.out_pc     = main_q.pc;
  assign bus.out_rd     = main_q.rd;
  assign bus.out_rs1    = main_q.rs1;
  assign bus.out_rs2    = main_q.rs2;
  assign bus.out_ctrl   = main_q.ctrl;
  assign bus.out_imm    = main_q.imm;
  assign bus.out_alu_op = main_q.alu_op;
  assign bus.out_func3  = main_q.func3;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: two instances (RV32E=0 and RV32E=1) share
// identical stimulus; each has its own expected-bundle queue and monitor.
module tb_decode_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .ALU_OP_W(4)) bus0 ();
  decode_stage_if #(.XLEN(32), .ALU_OP_W(4)) bus1 ();

  decode_stage #(.XLEN(32), .RV32E(0), .ALU_OP_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0)
  );
  decode_stage #(.XLEN(32), .RV32E(1), .ALU_OP_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [13:0] ctrl;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [2:0]  f3;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference decode straight from the ISA rules: immediates via signed arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] ins, input bit e);
    exp_t r;
    int   imm;
    bit   wen, r1, r2, si, br, jal, jalr, z, pcs, four, ld, st, md, ill;
    logic [2:0] f3;
    logic [6:0] f7;
    {wen, r1, r2, si, br, jal, jalr, z, pcs, four, ld, st, md, ill} = '0;
    r   = '0;
    imm = 0;
    f3  = ins[14:12];
    f7  = ins[31:25];
    case (ins[6:0])
      7'h33: begin
        wen = 1; r1 = 1; r2 = 1;
        r.alu = {f7[5], f3};
        if (f7 == 7'h01) begin
`ifdef DECODE_MEXT_EN
          md = 1;
`else
          ill = 1;
`endif
        end else begin
          ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end
      end
      7'h13: begin
        wen = 1; r1 = 1; si = 1;
        imm = 32'($signed(ins[31:20]));
        r.alu = {(f3 == 3'd5) ? f7[5] : 1'b0, f3};
        if (f3 == 3'd1) ill = (f7 != 7'h00);
        else if (f3 == 3'd5) ill = !(f7 == 7'h00 || f7 == 7'h20);
      end
      7'h03: begin
        wen = 1; r1 = 1; si = 1; ld = 1;
        imm = 32'($signed(ins[31:20]));
        ill = f3 inside {3'd3, 3'd6, 3'd7};
      end
      7'h23: begin
        r1 = 1; r2 = 1; si = 1; st = 1;
        imm = 32'($signed({ins[31:25], ins[11:7]}));
        ill = (f3 >= 3'd3);
      end
      7'h63: begin
        r1 = 1; r2 = 1; br = 1;
        imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
        ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h37: begin
        wen = 1; si = 1; z = 1;
        imm = {ins[31:12], 12'h000};
      end
      7'h17: begin
        wen = 1; si = 1; pcs = 1;
        imm = {ins[31:12], 12'h000};
      end
      7'h6F: begin
        wen = 1; jal = 1; pcs = 1; four = 1;
        imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      end
      7'h67: begin
        wen = 1; r1 = 1; jalr = 1; pcs = 1; four = 1;
        imm = 32'($signed(ins[31:20]));
        ill = (f3 != 3'd0);
      end
      default: ill = 1;
    endcase
    if (e && ((wen && ins[11:7] >= 5'd16) || (r1 && ins[19:15] >= 5'd16) ||
              (r2 && ins[24:20] >= 5'd16))) ill = 1;
    if (ill) {wen, ld, st, br, jal, jalr} = '0;
    r.ctrl = {md, st, ld, ill, four, pcs, z, jalr, jal, br, si, r2, r1, wen};
    r.pc   = pc;
    r.rd   = ins[11:7];
    r.rs1  = ins[19:15];
    r.rs2  = ins[24:20];
    r.imm  = imm;
    r.f3   = f3;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op, f7;
    r = $urandom();
    case ($urandom_range(0, 9))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h6F;
      8: op = 7'h67;  default: op = 7'($urandom());
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;  default: f7 = 7'($urandom());
    endcase
    return {f7, r[24:7], op};
  endfunction

  task automatic mon_one(input int id, input logic ov, input logic ir, input logic ordy, input exp_t act);
    int   sz;
    exp_t e;
    sz = (id == 0) ? q0.size() : q1.size();
    chk($sformatf("dut%0d out_valid", id), {31'd0, ov}, {31'd0, sz > 0});
    chk($sformatf("dut%0d in_ready", id), {31'd0, ir}, {31'd0, sz < 2});
    if (ov && ordy && sz > 0) begin
      if (id == 0) e = q0.pop_front();
      else e = q1.pop_front();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL dut%0d bundle: got pc=%h rd=%0d rs1=%0d rs2=%0d ctrl=%h imm=%h alu=%h f3=%0d expected pc=%h rd=%0d rs1=%0d rs2=%0d ctrl=%h imm=%h alu=%h f3=%0d",
                 id, act.pc, act.rd, act.rs1, act.rs2, act.ctrl, act.imm, act.alu, act.f3,
                 e.pc, e.rd, e.rs1, e.rs2, e.ctrl, e.imm, e.alu, e.f3);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(0, bus0.out_valid, bus0.in_ready, bus0.out_ready,
              {bus0.out_pc, bus0.out_rd, bus0.out_rs1, bus0.out_rs2, bus0.out_ctrl,
               bus0.out_imm, bus0.out_alu_op, bus0.out_func3});
      mon_one(1, bus1.out_valid, bus1.in_ready, bus1.out_ready,
              {bus1.out_pc, bus1.out_rd, bus1.out_rs1, bus1.out_rs2, bus1.out_ctrl,
               bus1.out_imm, bus1.out_alu_op, bus1.out_func3});
      if (flush) begin
        q0.delete();
        q1.delete();
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    bus0.in_valid = v;    bus1.in_valid = v;
    bus0.in_pc = pc;      bus1.in_pc = pc;
    bus0.in_instr = ins;  bus1.in_instr = ins;
    bus0.out_ready = ordy; bus1.out_ready = ordy;
    flush = fl;
  endtask

  // Advance one cycle; an accepted input pushes its expected bundle
  task automatic step();
    @(negedge clk); #1;
    if (rst_n && !flush) begin
      if (bus0.in_valid && bus0.in_ready) q0.push_back(ref_decode(bus0.in_pc, bus0.in_instr, 1'b0));
      if (bus1.in_valid && bus1.in_ready) q1.push_back(ref_decode(bus1.in_pc, bus1.in_instr, 1'b1));
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] ins);
    drive(1'b1, pc, ins, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk); #2;
  endtask

  task automatic resync();
    @(posedge clk); #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, bus0.in_ready}, 32'd1);
    chk("rst out_pc", bus0.out_pc, 32'd0);
    chk("rst out_ctrl", {18'd0, bus0.out_ctrl}, 32'd0);
    chk("rst out_imm", bus0.out_imm, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    resync();

    send(32'h0, 32'h00500093);
    chk("addi out_valid", {31'd0, bus0.out_valid}, 32'd1);
    chk("addi rd", {27'd0, bus0.out_rd}, 32'd1);
    chk("addi imm", bus0.out_imm, 32'd5);
    chk("addi ctrl", {18'd0, bus0.out_ctrl}, 32'h00B);
    chk("addi alu_op", {28'd0, bus0.out_alu_op}, 32'd0);
    resync();

    send(32'h100, 32'hFE208CE3);
    chk("beq ctrl", {18'd0, bus0.out_ctrl}, 32'h016);
    chk("beq imm", bus0.out_imm, 32'hFFFFFFF8);
    chk("beq func3", {29'd0, bus0.out_func3}, 32'd0);
    chk("beq pc", bus0.out_pc, 32'h100);
    resync();

    send(32'h104, 32'h010000EF);
    chk("jal imm", bus0.out_imm, 32'h10);
    chk("jal ctrl", {18'd0, bus0.out_ctrl}, 32'h321);
    resync();

    send(32'h108, 32'h00208833);
    chk("add x16 rv32i rd", {27'd0, bus0.out_rd}, 32'd16);
    chk("add x16 rv32i ctrl", {18'd0, bus0.out_ctrl}, 32'h007);
    chk("add x16 rv32e ctrl", {18'd0, bus1.out_ctrl}, 32'h406);
    resync();

    send(32'h10C, 32'h022081B3);
`ifdef DECODE_MEXT_EN
    chk("mul ctrl", {18'd0, bus0.out_ctrl}, 32'h2007);
`else
    chk("mul ctrl", {18'd0, bus0.out_ctrl}, 32'h406);
`endif
    chk("mul func3", {29'd0, bus0.out_func3}, 32'd0);
    resync();

    // Skid fill and in-order drain
    drive(1'b1, 32'h200, 32'h00100113, 1'b0, 1'b0); step();
    drive(1'b1, 32'h204, 32'h00200193, 1'b0, 1'b0); step();
    chk("skid in_ready", {31'd0, bus0.in_ready}, 32'd0);
    chk("skid head pc", bus0.out_pc, 32'h200);
    drive(1'b1, 32'h208, 32'h00300213, 1'b0, 1'b0); step();
    drive(1'b1, 32'h208, 32'h00300213, 1'b1, 1'b0); step();
    drive(1'b1, 32'h208, 32'h00300213, 1'b1, 1'b0); step();
    drive(1'b1, 32'h20C, 32'h00400293, 1'b1, 1'b0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) step();
    chk("skid drain empty", q0.size(), 32'd0);

    // Flush with the skid full
    drive(1'b1, 32'h300, 32'h00100113, 1'b0, 1'b0); step();
    drive(1'b1, 32'h304, 32'h00200193, 1'b0, 1'b0); step();
    chk("flush prefill in_ready", {31'd0, bus0.in_ready}, 32'd0);
    drive(1'b1, 32'h308, 32'h00300213, 1'b0, 1'b1); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); #2;
    chk("flush out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, bus0.in_ready}, 32'd1);
    resync();

    // Flush beats a simultaneous accept
    drive(1'b1, 32'h400, 32'h00100113, 1'b0, 1'b0); step();
    drive(1'b1, 32'h404, 32'h00200193, 1'b0, 1'b1); step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk); #2;
    chk("flush+accept out_valid", {31'd0, bus0.out_valid}, 32'd0);
    resync();
    repeat (3) step();

    repeat (3000) begin
      drive($urandom_range(0, 9) < 7, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rand_instr(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      step();
    end

    // Asynchronous reset with entries in flight
    drive(1'b1, 32'h500, 32'h00100113, 1'b0, 1'b0); step();
    drive(1'b1, 32'h504, 32'h00200193, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("midrst out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, bus0.in_ready}, 32'd1);
    chk("midrst out_pc", bus0.out_pc, 32'd0);
    resync();
    rst_n = 1'b1;
    repeat (4) step();
    chk("final q0 empty", q0.size(), 32'd0);
    chk("final q1 empty", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32 instruction-decode pipeline stage, placed between the fetch stage and the execute stage.
- Accepts {pc, instruction} over a valid/ready handshake and presents a one-cycle-latency registered decode bundle downstream.
- Contains a 2-entry skid buffer so that in_ready never depends combinationally on out_ready.
- Generalises the combinational decoder:
  - adds RV32E register-range checking;
  - produces correct B-type and J-type immediates;
  - applies stricter func7 legality checks;
  - supports flush.

Parameters:
XLEN, 32, datapath/pc/immediate width; only 32 supported, any other value is an elaboration error
RV32E, 0, 1 = 16-register base ISA; any rd/rs1/rs2 in use with index >= 16 raises ill_instr
ALU_OP_W, 4, alu_op width; bits[2:0]=func3, bit[3]=func7[5] for SUB/SRA/SRAI

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held/in-flight entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; equals !skid_valid (register-driven)
in_pc  in  XLEN  pc of instruction
in_instr  in  32  raw instruction
out_valid  out  1  decode bundle valid
out_ready  in  1  downstream accepts bundle
out_pc  out  XLEN  registered pc
out_rd / out_rs1 / out_rs2  out  5 each  register indices (instr[11:7], [19:15], [24:20])
out_ctrl  out  14  bit map: 0 reg_wen, 1 rs1_rd, 2 rs2_rd, 3 sel_imm, 4 br, 5 jal, 6 jalr, 7 op1_sel_zero, 8 op1_sel_pc, 9 op2_sel_4, 10 ill_instr, 11 mem_rd_en, 12 mem_wr_en, 13 muldiv
out_imm  out  XLEN  sign-extended immediate
out_alu_op  out  ALU_OP_W  ALU operation
out_func3  out  3  mem_rd_op / mem_wr_op / branch_op / muldiv_op source

Behaviour:
Reset (rst_n low, asynchronous):
- out_valid=0, skid_valid=0, every payload register = 0, in_ready=1.
- Reset asserted mid-transfer drops every entry.

Handshake:
- Input transfer when in_valid && in_ready.
- Output transfer when out_valid && out_ready.
- Accepted instruction appears on out_* on the next clk edge when the main register is free or draining; latency = 1 cycle.

Skid buffer:
- If the main register holds a stalled bundle (out_valid && !out_ready) and an input is accepted, the decoded input goes into the skid register and in_ready drops on the next cycle.
- When the main register drains, the skid entry moves into it the same edge and skid_valid clears.
- Order is always preserved.
- Full throughput: one transfer per cycle when out_ready stays high.
- Decode is done before the skid, so both entries hold decoded bundles.

Flush:
- Clears out_valid and skid_valid on the next edge.
- Has priority over a simultaneous input accept; the accepted input is discarded.
- in_ready=1 the cycle after flush.

Decode by opcode:
- OP (0110011): rs1/rs2 read, wen, alu_op={func7[5],func3}. Legal func7 is 0000000, or 0100000 only with func3 000/101; otherwise ill.
- OP-IMM (0010011): rs1 read, wen, sel_imm, alu_op[2:0]=func3. func3 001 needs func7=0000000; func3 101 needs func7 0000000/0100000, with alu_op[3]=func7[5]. Otherwise ill.
- LOAD: mem_rd_en, ADD, I-imm. func3 011/110/111 is ill.
- STORE: mem_wr_en, ADD, S-imm. func3[2]=1 or func3=011 is ill.
- BRANCH: br, B-imm = {instr[31]x20, instr[7], instr[30:25], instr[11:8], 0}. func3 010/011 is ill.
- LUI: op1_sel_zero, U-imm.
- AUIPC: op1_sel_pc, U-imm.
- JAL: jal, op1_sel_pc, op2_sel_4, wen, J-imm = {instr[31]x12, instr[19:12], instr[20], instr[30:21], 0}.
- JALR: jalr, rs1 read, same operand selects as JAL, I-imm. func3!=000 is ill.
- All other opcodes are ill.

Illegal-instruction handling:
- An ill entry still flows through with ctrl[10]=1.
- reg_wen, mem_rd_en, mem_wr_en, br, jal, jalr are forced to 0.

RV32E=1:
- Any used index with bit4=1 sets ill.
- Unused fields are ignored (e.g. rs2 of OP-IMM).

Optional Feature:
DECODE_MEXT_EN:
- Defined: OP with func7=0000001 is legal; sets muldiv=1 (ctrl[13]), rs1/rs2 read, wen, out_func3 = muldiv op.
- Undefined: that encoding is ill; ctrl[13] is tied to 0.

Test Plan:
1. Reset, then 0x00500093 (addi x1,x0,5) with out_ready=1 -> out_valid high 1 cycle later; rd=1, imm=5, ctrl wen|rs1_rd|sel_imm, alu_op=0000.
2. 0xFE208CE3 (beq x1,x2,-8) at pc 0x100 -> br=1, imm=0xFFFFFFF8, func3=000. Then 0x010000EF (jal x1,16) -> imm=0x10, jal/op1_sel_pc/op2_sel_4 set.
3. Stream 4 instrs, out_ready low after the first lands -> second enters skid, in_ready=0. Raise out_ready -> all 4 exit in order, one per cycle, none lost or duplicated.
4. Skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input never appears.
5. RV32E=1: 0x00208833 (add x16,x1,x2) -> ill=1, wen=0. Same with RV32E=0 -> legal, rd=16.
6. 0x022081B3 (mul x3,x1,x2): with DECODE_MEXT_EN -> muldiv=1, func3=000, wen=1. Without it -> ill=1.
